// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// A global enable freezes everything; flush discards held entries and optionally leaves a redirect bubble.
module pipe_skid_stage #(
    parameter int PC_W         = 32,
    parameter int DATA_W       = 32,
    parameter int META_W       = 2,
    parameter int FLUSH_BUBBLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [META_W-1:0] in_meta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [META_W-1:0] out_meta,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        H_HOLD  = 2'd0,
        H_IN    = 2'd1,
        H_SKID  = 2'd2,
        H_FLUSH = 2'd3
    } head_sel_t;

    state_t            state_p0;
    state_t            state_nxt;
    head_sel_t         head_sel;
    logic              skid_ld;
    logic              in_fire;
    logic              out_fire;
    logic [PC_W-1:0]   skid_pc_p0;
    logic [DATA_W-1:0] skid_data_p0;
    logic [META_W-1:0] skid_meta_p0;

    function automatic logic [1:0] occ_of(input state_t s);
        case (s)
            ONE:     occ_of = 2'd1;
            FULL:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

    // in_ready and out_valid are registered, so neither fire term sees out_ready combinationally in in_ready
    assign in_fire  = enable & in_valid & in_ready;
    assign out_fire = enable & out_valid & out_ready;

    always_comb begin
        state_nxt = state_p0;
        head_sel  = H_HOLD;
        skid_ld   = 1'b0;
        if (enable) begin
            if (flush) begin
                head_sel = H_FLUSH;
                if (FLUSH_BUBBLE != 0) state_nxt = ONE;
                else                   state_nxt = EMPTY;
            end else begin
                case (state_p0)
                    EMPTY: begin
                        if (in_fire) begin
                            state_nxt = ONE;
                            head_sel  = H_IN;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            head_sel = H_IN;
                        end else if (in_fire) begin
                            state_nxt = FULL;
                            skid_ld   = 1'b1;
                        end else if (out_fire) begin
                            state_nxt = EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            state_nxt = ONE;
                            head_sel  = H_SKID;
                        end
                    end
                    default: state_nxt = EMPTY;
                endcase
            end
        end
    end

    // Stage boundary: head and skid registers, plus registered handshake outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_p0     <= EMPTY;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
            occupancy    <= 2'd0;
            out_pc       <= '0;
            out_data     <= '0;
            out_meta     <= '0;
            skid_pc_p0   <= '0;
            skid_data_p0 <= '0;
            skid_meta_p0 <= '0;
        end else begin
            state_p0  <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
            occupancy <= occ_of(state_nxt);
            case (head_sel)
                H_IN: begin
                    out_pc   <= in_pc;
                    out_data <= in_data;
                    out_meta <= in_meta;
                end
                H_SKID: begin
                    out_pc   <= skid_pc_p0;
                    out_data <= skid_data_p0;
                    out_meta <= skid_meta_p0;
                end
                H_FLUSH: begin
                    out_pc   <= flush_pc;
                    out_data <= '0;
                    out_meta <= '0;
                end
                default: ;
            endcase
            if (skid_ld) begin
                skid_pc_p0   <= in_pc;
                skid_data_p0 <= in_data;
                skid_meta_p0 <= in_meta;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vectors feed a queue scoreboard; a negedge monitor pops on each out_fire.
module tb_pipe_skid_stage;

    localparam int PC_W   = 32;
    localparam int DATA_W = 64;
    localparam int META_W = 5;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [META_W-1:0] meta;
    } ent_t;

    logic              clock = 1'b0;
    logic              reset, enable, flush, in_valid, out_ready;
    logic [PC_W-1:0]   flush_pc, in_pc;
    logic [DATA_W-1:0] in_data;
    logic [META_W-1:0] in_meta;

    logic              in_ready, out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    logic [META_W-1:0] out_meta;
    logic [1:0]        occupancy;

    logic              nb_in_ready, nb_out_valid;
    logic [PC_W-1:0]   nb_out_pc;
    logic [DATA_W-1:0] nb_out_data;
    logic [META_W-1:0] nb_out_meta;
    logic [1:0]        nb_occupancy;

    ent_t q[$];
    logic ready_m = 1'b1;
    logic started = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    pipe_skid_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .META_W(META_W), .FLUSH_BUBBLE(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush), .flush_pc(flush_pc),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data), .in_meta(in_meta),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
        .out_meta(out_meta), .occupancy(occupancy)
    );

    pipe_skid_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .META_W(META_W), .FLUSH_BUBBLE(0)) dut_nb (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush), .flush_pc(flush_pc),
        .in_valid(in_valid), .in_ready(nb_in_ready), .in_pc(in_pc), .in_data(in_data), .in_meta(in_meta),
        .out_valid(nb_out_valid), .out_ready(out_ready), .out_pc(nb_out_pc), .out_data(nb_out_data),
        .out_meta(nb_out_meta), .occupancy(nb_occupancy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare state against the queue model, pop whenever the head is accepted.
    always @(negedge clock) begin
        if (started) begin
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready",  64'(in_ready),  64'(q.size() != 2));
            ready_m = (q.size() != 2);
            if (enable && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("pop_empty", 64'(1), 64'(0));
                end else begin
                    chk("out_pc",   64'(out_pc),   64'(q[0].pc));
                    chk("out_data", out_data,      q[0].data);
                    chk("out_meta", 64'(out_meta), 64'(q[0].meta));
                    void'(q.pop_front());
                end
            end
        end
    end

    // Advance one clock and apply the same edge to the queue model.
    task automatic step();
        ent_t e;
        @(posedge clock);
        if (!reset) begin
            q.delete();
        end else if (enable) begin
            if (flush) begin
                q.delete();
                e.pc = flush_pc; e.data = '0; e.meta = '0;
                q.push_back(e);
            end else if (in_valid && ready_m) begin
                e.pc = in_pc; e.data = in_data; e.meta = in_meta;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [63:0] d, input logic [4:0] m);
        in_valid = v; in_pc = pc; in_data = d; in_meta = m;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
        drive(1'b1, 32'h55, 64'hAA, 5'h3);
        repeat (3) step();
        chk("rst_occ",   64'(occupancy), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_ready", 64'(in_ready),  64'(1));
        chk("rst_pc",    64'(out_pc),    64'(0));
        chk("rst_data",  out_data,       64'(0));
        chk("rst_meta",  64'(out_meta),  64'(0));
        reset = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 5'h0);
        started = 1'b1;
        step();

        // Streaming: one entry in, one out every cycle
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 64'h1234_0000_0000_00D0 + 64'(i), 5'(i + 1));
            step();
            chk("stream_pc",  64'(out_pc),    64'(32'h100 + 32'(4 * i)));
            chk("stream_occ", 64'(occupancy), 64'(1));
        end
        drive(1'b0, 32'h0, 64'h0, 5'h0);
        step();
        chk("stream_drain", 64'(occupancy), 64'(0));

        // Skid: downstream stalls while upstream keeps issuing
        drive(1'b1, 32'h200, 64'hA0, 5'h1);
        step();
        chk("skid_occ1", 64'(occupancy), 64'(1));
        out_ready = 1'b0;
        drive(1'b1, 32'h204, 64'hA1, 5'h2);
        step();
        chk("skid_occ2",   64'(occupancy), 64'(2));
        chk("skid_ready0", 64'(in_ready),  64'(0));
        chk("skid_head",   64'(out_pc),    64'(32'h200));
        drive(1'b1, 32'h208, 64'hA2, 5'h3);
        step();
        chk("skid_hold", 64'(out_pc), 64'(32'h200));
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 5'h0);
        step();
        chk("skid_second", 64'(out_pc),    64'(32'h204));
        chk("skid_occ_r",  64'(occupancy), 64'(1));
        step();
        chk("skid_empty", 64'(occupancy), 64'(0));

        // Flush with two entries held and a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 64'hB0, 5'h4); step();
        drive(1'b1, 32'h304, 64'hB1, 5'h5); step();
        chk("pre_flush_occ", 64'(nb_occupancy), 64'(2));
        flush = 1'b1; flush_pc = 32'hBFC0_0380;
        drive(1'b1, 32'h308, 64'hB2, 5'h6);
        step();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'(1));
        chk("flush_pc",    64'(out_pc),    64'(32'hBFC0_0380));
        chk("flush_data",  out_data,       64'(0));
        chk("flush_meta",  64'(out_meta),  64'(0));
        chk("flush_occ",   64'(occupancy), 64'(1));
        chk("nb_valid",    64'(nb_out_valid), 64'(0));
        chk("nb_occ",      64'(nb_occupancy), 64'(0));
        chk("nb_ready",    64'(nb_in_ready),  64'(1));

        // Freeze: nothing moves while enable is low, even with flush and handshakes asserted
        enable = 1'b0; flush = 1'b1; flush_pc = 32'h0000_DEAD; out_ready = 1'b1;
        drive(1'b1, 32'h400, 64'hC0, 5'h7);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_pc",    64'(out_pc),    64'(32'hBFC0_0380));
            chk("frz_valid", 64'(out_valid), 64'(1));
            chk("frz_occ",   64'(occupancy), 64'(1));
        end
        enable = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 5'h0);
        step();
        chk("frz_drain", 64'(occupancy), 64'(0));

        // Mixed traffic with stalls, freezes, flushes and occasional reset
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 499) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            flush_pc  = $urandom;
            out_ready = $urandom_range(0, 1) == 1;
            drive($urandom_range(0, 2) != 0, $urandom, {$urandom, $urandom}, 5'($urandom));
            step();
        end
        reset = 1'b1; enable = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 5'h0);
        repeat (3) step();
        chk("final_occ", 64'(occupancy), 64'(0));

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
